// File: rtl/state_dump_tx.sv
// rtl/state_dump_tx.sv - streams register-file and data-memory state as a checksummed byte frame
module state_dump_tx #(
    parameter int          NUM_REGS = 32,
    parameter int          NUM_MEM  = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_LD_REG = 3'd2;
    localparam logic [2:0] S_TX_REG = 3'd3;
    localparam logic [2:0] S_LD_MEM = 3'd4;
    localparam logic [2:0] S_TX_MEM = 3'd5;
    localparam logic [2:0] S_CSUM   = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LAST_MEM = ADDR_W'(NUM_MEM - 1);

    logic [2:0]        r_state;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_csum;
    logic [31:0]       r_word_q;

    logic              w_hs;
    logic [1:0]        w_byte_nxt;
    logic [7:0]        w_next_byte;
    logic [7:0]        w_csum_nxt;

    assign w_hs       = r_tx_valid & tx_ready;
    assign w_byte_nxt = r_byte_idx + 2'd1;
    assign w_csum_nxt = r_csum ^ r_tx_data;

    always_comb begin
        w_next_byte = r_word_q[7:0];
        case (w_byte_nxt)
            2'd1:    w_next_byte = r_word_q[15:8];
            2'd2:    w_next_byte = r_word_q[23:16];
            2'd3:    w_next_byte = r_word_q[31:24];
            default: w_next_byte = r_word_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_reg_addr <= '0;
            r_mem_addr <= '0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
            r_word_q   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        r_busy     <= 1'b1;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HEADER;
                        r_word_idx <= '0;
                        r_byte_idx <= 2'd0;
                        r_csum     <= 8'd0;
                        r_reg_addr <= '0;
                        r_mem_addr <= '0;
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        r_state    <= S_LD_REG;
                        r_tx_valid <= 1'b0;
                    end
                end
                // Capture the whole word once so later read-data changes cannot leak into the frame.
                S_LD_REG: begin
                    r_word_q   <= reg_data;
                    r_tx_data  <= reg_data[7:0];
                    r_tx_valid <= 1'b1;
                    r_state    <= S_TX_REG;
                end
                S_LD_MEM: begin
                    r_word_q   <= mem_data;
                    r_tx_data  <= mem_data[7:0];
                    r_tx_valid <= 1'b1;
                    r_state    <= S_TX_MEM;
                end
                S_TX_REG, S_TX_MEM: begin
                    if (w_hs) begin
                        r_csum     <= w_csum_nxt;
                        r_byte_idx <= w_byte_nxt;
                        if (r_byte_idx != 2'd3) begin
                            r_tx_data <= w_next_byte;
                        end else if (r_state == S_TX_REG) begin
                            r_tx_valid <= 1'b0;
                            if (r_word_idx == LAST_REG) begin
                                r_word_idx <= '0;
                                r_mem_addr <= '0;
                                r_state    <= S_LD_MEM;
                            end else begin
                                r_word_idx <= r_word_idx + 1'b1;
                                r_reg_addr <= r_word_idx + 1'b1;
                                r_state    <= S_LD_REG;
                            end
                        end else if (r_word_idx == LAST_MEM) begin
                            r_tx_data <= w_csum_nxt;
                            r_state   <= S_CSUM;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_word_idx <= r_word_idx + 1'b1;
                            r_mem_addr <= r_word_idx + 1'b1;
                            r_state    <= S_LD_MEM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_hs) begin
                        r_state    <= S_IDLE;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign reg_addr = r_reg_addr;
    assign mem_addr = r_mem_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_state_dump_tx.sv
// tb/tb_state_dump_tx.sv - randomized frame checks of state_dump_tx against a byte-list reference model
module tb_state_dump_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [31:0] mem  [32];
    logic [31:0] noise;
    bit          perturb;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  got [$];

    always #5 clk = ~clk;

    // While a byte is on the wire the read ports return junk; only a load cycle sees real data.
    assign reg_data = (perturb && tx_valid) ? noise : regs[reg_addr];
    assign mem_data = (perturb && tx_valid) ? ~noise : mem[mem_addr];

    state_dump_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int w = 0; w < 64; w++) begin
            logic [31:0] word;
            word = (w < 32) ? regs[w] : mem[w - 32];
            for (int b = 0; b < 4; b++) begin
                logic [7:0] byt;
                byt = 8'((word >> (8 * b)) & 32'hFF);
                exp_q.push_back(byt);
                cs ^= byt;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 32; i++) begin
            regs[i] = rnd ? $urandom() : 32'd0;
            mem[i]  = rnd ? $urandom() : 32'd0;
        end
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random stalls
    task automatic run_frame(input int rdy_mode, input bit pulses, input bit pert);
        int         cyc;
        int         done_cnt;
        int         done_cyc;
        int         busy_cnt;
        bit         prev_stall;
        logic [7:0] prev_data;
        build_exp();
        got.delete();
        perturb    = pert;
        done_cnt   = 0;
        done_cyc   = 0;
        busy_cnt   = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("hdr_valid_cyc1", {31'd0, tx_valid}, 32'd1);
        while (cyc < 3000 && (done_cyc == 0 || cyc < done_cyc + 20)) begin
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = cyc[0];
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = pulses && (cyc == 10 || cyc == 200);
            noise = $urandom();
            if (prev_stall) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        tx_ready = 1'b0;
        perturb  = 1'b0;
        check("done_seen", {31'd0, done_cyc != 0}, 32'd1);
        check("done_count", done_cnt, 32'd1);
        check("busy_cycles", busy_cnt, done_cyc - 1);
        if (rdy_mode == 0) check("done_cycle", done_cyc, 32'd323);
        check("frame_len", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
                  {24'd0, exp_q[i]});
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        perturb  = 1'b0;
        noise    = 32'd0;
        fill(1'b0);
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0, 1'b0);

        regs[1] = 32'hDEADBEEF;
        run_frame(0, 1'b0, 1'b0);
        if (got.size() == 258) check("csum_deadbeef", {24'd0, got[257]}, 32'h22);

        fill(1'b0);
        mem[31] = 32'h12345678;
        run_frame(1, 1'b0, 1'b0);
        if (got.size() == 258) check("csum_mem31", {24'd0, got[257]}, 32'h08);

        fill(1'b1);
        run_frame(0, 1'b0, 1'b1);

        fill(1'b1);
        run_frame(0, 1'b1, 1'b0);

        for (int k = 0; k < 2; k++) begin
            fill(1'b1);
            run_frame(2, 1'b0, 1'b0);
        end

        fill(1'b1);
        @(negedge clk);
        start    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_valid_hold", {31'd0, tx_valid}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b1;
        tx_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, busy, done}, 32'd0);
        end
        run_frame(0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
